demux_1ton_press_router: RTL and testbench
==========================================

Name: demux_1ton_press_router

Overview:
- Parametrised successor of the 1-to-2 press demux. Routes a button press on data_in to one of NUM_CH channels chosen by the sel switches.
- Adds:
  - 2-flop synchronisation of data_in and sel.
  - Rising-edge detection, producing one single-cycle pulse per press.
  - A hold-off window that rejects re-presses.
  - Per-channel press counters.
  - Invalid-select detection.
- Sits between the board button/switch inputs and the per-queue (A/B/...) counter logic.

Parameters:
- NUM_CH, 4, number of output channels (>=2).
- HOLDOFF, 16, cycles the router stays busy after a routed press (>=1).
- CNT_W, 8, width of each per-channel press counter.
- SEL_W, $clog2(NUM_CH), localparam, width of sel (not overridable).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- data_in  in  1  raw press level from button.
- sel  in  SEL_W  raw channel select from switches.
- en  in  1  routing enable; presses ignored while low.
- clr_cnt  in  1  synchronous clear of all counters and bad_sel.
- out_pulse  out  NUM_CH  one-hot, single-cycle routed press.
- active_ch  out  SEL_W  index of last routed channel.
- busy  out  1  high while in HOLD.
- bad_sel  out  1  sticky flag: press seen with sel >= NUM_CH.
- cnt_flat  out  NUM_CH*CNT_W  per-channel counters, channel i at bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset: one clock, synchronous, active-high; named clk and rst.
- Reset values:
  - data_in sync stages and prev register load 1, so a press held through reset never fires.
  - sel sync stages load 0.
  - out_pulse=0, active_ch=0, busy=0, bad_sel=0, all counters=0, state=IDLE.
- Sync path: sync0<=data_in, sync1<=sync0, prev<=sync1. Each sel bit goes through an identical 2-flop chain, so routing uses the sel value sampled together with data_in.
- rise = sync1 & ~prev (combinational).
- Latency: data_in first sampled high at edge E0 -> out_pulse high for exactly the cycle after edge E0+2. Holding the button longer produces no further pulses.
- FSM states:
  - IDLE:
    - If rise & en & sel_sync<NUM_CH: out_pulse[sel_sync]<=1, active_ch<=sel_sync, counter[sel_sync]++, timer<=HOLDOFF-1, go to HOLD.
    - If rise & en & sel_sync>=NUM_CH: no pulse, bad_sel<=1, stay in IDLE.
    - If en=0: rise ignored.
  - HOLD:
    - busy=1; rise ignored (no pulse, no count, no bad_sel).
    - timer decrements each cycle; at timer==0, next state is IDLE.
    - busy is high for exactly HOLDOFF cycles, starting the same cycle as out_pulse.
    - en has no effect in HOLD.
- A rise in the first IDLE cycle after HOLD is accepted.
- Counters wrap: 2^CNT_W-1 + 1 -> 0, with no saturation and no flag.
- clr_cnt:
  - Clears all counters and bad_sel.
  - If coincident with a routed press, the clear applies first, then the increment: that counter becomes 1.
  - If coincident with an invalid press, bad_sel ends at 1.
  - Does not affect state, timer, busy or active_ch.
- out_pulse is always one-hot or zero and never high for two consecutive cycles.
- rst mid-HOLD: everything returns to reset values on the next edge; a pulse in flight is dropped.

Decomposition:
- Shared package qar_demux_pkg holds:
  - state typedef (IDLE, HOLD).
  - Default constants: DEF_NUM_CH=4, DEF_HOLDOFF=16, DEF_CNT_W=8.
- One sub-module, sync_2ff: 1-bit 2-stage synchroniser with parameter RST_VAL.
  - Instantiated once for data_in with RST_VAL=1.
  - Instantiated SEL_W times for sel with RST_VAL=0.
- Edge detect, FSM and counters stay in the top module.

Test Plan:
1. data_in=1 held through reset and 20 cycles after release -> out_pulse=0 throughout, all counters 0, busy=0.
2. NUM_CH=4, HOLDOFF=16: sel=2, data_in 0->1 first sampled at edge E0, held 5 cycles -> out_pulse=4'b0100 only in the cycle after E0+2, counter2=1, active_ch=2, busy high exactly 16 cycles.
3. Second press on sel=1 at 5 cycles after the first pulse -> no pulse, counter1=0. Press again after busy falls -> out_pulse=4'b0010, counter1=1. Assert rst mid-HOLD -> busy=0 and all counters 0 on the next edge.
4. NUM_CH=3, sel=3, press -> out_pulse=0, bad_sel=1 (stays 1), busy=0. Then clr_cnt for 1 cycle -> bad_sel=0.
5. CNT_W=2, HOLDOFF=4: five separated presses on ch0 -> counter0 sequence 1,2,3,0,1. Repeat with en=0 -> no pulses, counter unchanged.
6. Counter1=7: clr_cnt in the same cycle as a routed press on ch1 -> counter1=1, all other counters=0, out_pulse=4'b0010.

Source files
------------

// File: rtl/qar_demux_pkg.sv
// Shared types and default sizing for the press router family.
package qar_demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_HOLDOFF = 16;
    localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/demux_1ton_press_router_sync_2ff.sv
// One-bit two-stage synchroniser with a selectable reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/demux_1ton_press_router.sv
// Routes each synchronised button press to one of NUM_CH channels, with a
// hold-off window, per-channel press counters and an invalid-select flag.
module demux_1ton_press_router
    import qar_demux_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int HOLDOFF = DEF_HOLDOFF,
    parameter int CNT_W   = DEF_CNT_W,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_in,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    en,
    input  logic                    clr_cnt,
    output logic [NUM_CH-1:0]       out_pulse,
    output logic [SEL_W-1:0]        active_ch,
    output logic                    busy,
    output logic                    bad_sel,
    output logic [NUM_CH*CNT_W-1:0] cnt_flat
);

    localparam int                TMR_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(HOLDOFF - 1);
    localparam logic [SEL_W:0]    NUM_CH_V = (SEL_W + 1)'(NUM_CH);

    logic             data_sync_p1;
    logic             prev_p2;
    logic [SEL_W-1:0] sel_sync_p1;
    logic             rise;
    logic             sel_ok;

    state_t           state;
    state_t           state_d;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_d;
    logic             accept;
    logic             reject;
    logic [NUM_CH-1:0] pulse_d;

    logic [CNT_W-1:0] cnt_q [NUM_CH];

    // Stage p0/p1: synchronisers; data resets high so a held press never fires.
    sync_2ff #(.RST_VAL(1'b1)) u_sync_data (
        .clk (clk),
        .rst (rst),
        .d   (data_in),
        .q   (data_sync_p1)
    );

    for (genvar g = 0; g < SEL_W; g++) begin : gen_sel_sync
        sync_2ff #(.RST_VAL(1'b0)) u_sync_sel (
            .clk (clk),
            .rst (rst),
            .d   (sel[g]),
            .q   (sel_sync_p1[g])
        );
    end

    // Stage p2: previous level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) prev_p2 <= 1'b1;
        else     prev_p2 <= data_sync_p1;
    end

    assign rise   = data_sync_p1 & ~prev_p2;
    assign sel_ok = {1'b0, sel_sync_p1} < NUM_CH_V;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_d;
            timer <= timer_d;
        end
    end

    always_comb begin
        state_d = state;
        timer_d = timer;
        accept  = 1'b0;
        reject  = 1'b0;
        pulse_d = '0;
        case (state)
            IDLE: begin
                if (rise && en) begin
                    if (sel_ok) begin
                        accept  = 1'b1;
                        state_d = HOLD;
                        timer_d = TMR_LOAD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (timer == '0) state_d = IDLE;
                else             timer_d = timer - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            pulse_d[i] = accept && (sel_sync_p1 == SEL_W'(i));
        end
    end

    // Registered outputs; a set of bad_sel overrides a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pulse <= '0;
            active_ch <= '0;
            bad_sel   <= 1'b0;
        end else begin
            out_pulse <= pulse_d;
            if (accept)  active_ch <= sel_sync_p1;
            if (clr_cnt) bad_sel   <= 1'b0;
            if (reject)  bad_sel   <= 1'b1;
        end
    end

    // Clear takes effect before a coincident increment, so that counter lands on 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pulse_d[i])   cnt_q[i] <= clr_cnt ? CNT_W'(1) : cnt_q[i] + CNT_W'(1);
                else if (clr_cnt) cnt_q[i] <= '0;
            end
        end
    end

    assign busy = (state == HOLD);

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_cnt_flat
        assign cnt_flat[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_demux_1ton_press_router.sv
// Bench for demux_1ton_press_router: default build (4 ch, hold 16, 8-bit counters)
// and a small build (3 ch, hold 4, 2-bit counters) driven side by side.
module tb_demux_1ton_press_router;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_d, a_en, a_clr;
    logic [1:0]  a_sel;
    logic [3:0]  a_pulse;
    logic [1:0]  a_act;
    logic        a_busy, a_bad;
    logic [31:0] a_cnt;

    logic        b_d, b_en, b_clr;
    logic [1:0]  b_sel;
    logic [2:0]  b_pulse;
    logic [1:0]  b_act;
    logic        b_busy, b_bad;
    logic [5:0]  b_cnt;

    demux_1ton_press_router #(.NUM_CH(4), .HOLDOFF(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .data_in(a_d), .sel(a_sel), .en(a_en), .clr_cnt(a_clr),
        .out_pulse(a_pulse), .active_ch(a_act), .busy(a_busy), .bad_sel(a_bad),
        .cnt_flat(a_cnt)
    );

    demux_1ton_press_router #(.NUM_CH(3), .HOLDOFF(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .data_in(b_d), .sel(b_sel), .en(b_en), .clr_cnt(b_clr),
        .out_pulse(b_pulse), .active_ch(b_act), .busy(b_busy), .bad_sel(b_bad),
        .cnt_flat(b_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: raw-sample history, remaining hold-off cycles, counts.
    int m_dh   [2][4];
    int m_sh   [2][4];
    int m_cnt  [2][4];
    int m_bad  [2];
    int m_left [2];
    int m_pulse[2];
    int m_act  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input int k, input int nc, input int hold, input int cw,
                              input logic r, input logic d, input logic [1:0] s,
                              input logic e, input logic c);
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_dh[k][i]  = 1;
                m_sh[k][i]  = 0;
                m_cnt[k][i] = 0;
            end
            m_bad[k] = 0; m_left[k] = 0; m_pulse[k] = 0; m_act[k] = 0;
            return;
        end
        for (int i = 3; i > 0; i--) begin
            m_dh[k][i] = m_dh[k][i-1];
            m_sh[k][i] = m_sh[k][i-1];
        end
        m_dh[k][0] = int'(d);
        m_sh[k][0] = int'(s);
        m_pulse[k] = 0;
        if (c) begin
            for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
            m_bad[k] = 0;
        end
        if (m_left[k] > 0) begin
            m_left[k]--;
        end else if (m_dh[k][2] == 1 && m_dh[k][3] == 0 && e) begin
            if (m_sh[k][2] < nc) begin
                m_pulse[k] = 1 << m_sh[k][2];
                m_act[k]   = m_sh[k][2];
                m_cnt[k][m_sh[k][2]] = (m_cnt[k][m_sh[k][2]] + 1) % (1 << cw);
                m_left[k]  = hold;
            end else begin
                m_bad[k] = 1;
            end
        end
    endtask

    task automatic compare_model();
        chk("a_pulse_model", 32'(a_pulse), m_pulse[0]);
        chk("a_busy_model",  32'(a_busy),  32'(m_left[0] > 0));
        chk("a_act_model",   32'(a_act),   m_act[0]);
        chk("a_bad_model",   32'(a_bad),   m_bad[0]);
        for (int i = 0; i < 4; i++) chk("a_cnt_model", 32'(a_cnt[i*8 +: 8]), m_cnt[0][i]);
        chk("b_pulse_model", 32'(b_pulse), m_pulse[1]);
        chk("b_busy_model",  32'(b_busy),  32'(m_left[1] > 0));
        chk("b_act_model",   32'(b_act),   m_act[1]);
        chk("b_bad_model",   32'(b_bad),   m_bad[1]);
        for (int i = 0; i < 3; i++) chk("b_cnt_model", 32'(b_cnt[i*2 +: 2]), m_cnt[1][i]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, 4, 16, 8, rst, a_d, a_sel, a_en, a_clr);
        model_step(1, 3, 4, 2, rst, b_d, b_sel, b_en, b_clr);
        #1;
        compare_model();
    endtask

    // Raise data_in, let it reach the decision edge, then release it.
    task automatic press_a(input logic [1:0] s, input logic c);
        a_sel = s; a_d = 1'b1;
        tick(); tick();
        a_clr = c;
        tick();
        a_clr = 1'b0; a_d = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (a_busy && n < 60) begin
            tick();
            n++;
        end
        chk("a_busy_timeout", 32'(a_busy), 32'd0);
        tick();
    endtask

    typedef struct {
        logic [1:0] sel;
        logic       en;
        logic       clr;
        int         ch;
        logic [2:0] pulse;
        logic [1:0] cnt;
        logic       bad;
        logic       busy;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int busy_cycles;
        int extra_pulses;

        tbl[0]  = '{2'd3, 1'b1, 1'b0, 0, 3'b000, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{2'd1, 1'b0, 1'b0, 1, 3'b000, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{2'd0, 1'b0, 1'b1, 0, 3'b000, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{2'd0, 1'b1, 1'b0, 0, 3'b001, 2'd1, 1'b0, 1'b1};
        tbl[4]  = '{2'd0, 1'b1, 1'b0, 0, 3'b001, 2'd2, 1'b0, 1'b1};
        tbl[5]  = '{2'd0, 1'b1, 1'b0, 0, 3'b001, 2'd3, 1'b0, 1'b1};
        tbl[6]  = '{2'd0, 1'b1, 1'b0, 0, 3'b001, 2'd0, 1'b0, 1'b1};
        tbl[7]  = '{2'd0, 1'b1, 1'b0, 0, 3'b001, 2'd1, 1'b0, 1'b1};
        tbl[8]  = '{2'd0, 1'b0, 1'b0, 0, 3'b000, 2'd1, 1'b0, 1'b0};
        tbl[9]  = '{2'd0, 1'b0, 1'b0, 0, 3'b000, 2'd1, 1'b0, 1'b0};
        tbl[10] = '{2'd2, 1'b1, 1'b0, 2, 3'b100, 2'd1, 1'b0, 1'b1};

        rst = 1'b1;
        a_d = 1'b1; a_sel = 2'd0; a_en = 1'b1; a_clr = 1'b0;
        b_d = 1'b1; b_sel = 2'd0; b_en = 1'b1; b_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_dh[0][i] = 1; m_dh[1][i] = 1;
        end
        tick(); tick(); tick();

        // Press held through reset must never fire.
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("held_reset_a_pulse", 32'(a_pulse), 32'd0);
            chk("held_reset_b_pulse", 32'(b_pulse), 32'd0);
        end
        chk("held_reset_a_cnt", a_cnt, 32'd0);
        chk("held_reset_busy", 32'(a_busy), 32'd0);
        a_d = 1'b0; b_d = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Latency: first sampled at E0, pulse after E0+2, busy for exactly 16 cycles.
        a_sel = 2'd2; a_d = 1'b1;
        tick();
        chk("lat_e0_pulse", 32'(a_pulse), 32'd0);
        tick();
        chk("lat_e1_pulse", 32'(a_pulse), 32'd0);
        tick();
        chk("lat_e2_pulse", 32'(a_pulse), 32'b0100);
        chk("lat_busy", 32'(a_busy), 32'd1);
        chk("lat_active", 32'(a_act), 32'd2);
        chk("lat_cnt2", 32'(a_cnt[16 +: 8]), 32'd1);
        busy_cycles = 1;
        extra_pulses = 0;
        for (int j = 0; j < 25; j++) begin
            if (j == 2) a_d = 1'b0;
            tick();
            if (a_busy) busy_cycles++;
            if (a_pulse != 4'b0) extra_pulses++;
        end
        chk("busy_width", busy_cycles, 32'd16);
        chk("held_extra_pulses", extra_pulses, 32'd0);

        // Re-press during hold-off is swallowed; accepted once idle again.
        press_a(2'd0, 1'b0);
        chk("ch0_pulse", 32'(a_pulse), 32'b0001);
        for (int i = 0; i < 4; i++) tick();
        a_sel = 2'd1; a_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("holdoff_no_pulse", 32'(a_pulse), 32'd0);
        end
        a_d = 1'b0;
        tick();
        chk("holdoff_cnt1", 32'(a_cnt[8 +: 8]), 32'd0);
        wait_idle_a();
        press_a(2'd1, 1'b0);
        chk("after_hold_pulse", 32'(a_pulse), 32'b0010);
        chk("after_hold_cnt1", 32'(a_cnt[8 +: 8]), 32'd1);
        wait_idle_a();
        press_a(2'd3, 1'b0);
        chk("ch3_pulse", 32'(a_pulse), 32'b1000);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("rst_hold_busy", 32'(a_busy), 32'd0);
        chk("rst_hold_cnt", a_cnt, 32'd0);
        chk("rst_hold_active", 32'(a_act), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Clear coincident with a routed press lands that counter on 1.
        press_a(2'd0, 1'b0);
        wait_idle_a();
        for (int n = 0; n < 7; n++) begin
            press_a(2'd1, 1'b0);
            wait_idle_a();
        end
        chk("pre_clr_cnt1", 32'(a_cnt[8 +: 8]), 32'd7);
        chk("pre_clr_cnt0", 32'(a_cnt[0 +: 8]), 32'd1);
        press_a(2'd1, 1'b1);
        chk("clr_press_pulse", 32'(a_pulse), 32'b0010);
        chk("clr_press_cnt", a_cnt, 32'h0000_0100);
        wait_idle_a();

        // Small build: invalid select, sticky flag, clear, wrap, enable gating.
        for (int r = 0; r < 11; r++) begin
            b_sel = tbl[r].sel; b_en = tbl[r].en; b_d = 1'b1;
            tick(); tick();
            b_clr = tbl[r].clr;
            tick();
            b_clr = 1'b0; b_d = 1'b0;
            chk("tbl_pulse", 32'(b_pulse), 32'(tbl[r].pulse));
            chk("tbl_cnt",   32'(b_cnt[tbl[r].ch*2 +: 2]), 32'(tbl[r].cnt));
            chk("tbl_bad",   32'(b_bad), 32'(tbl[r].bad));
            chk("tbl_busy",  32'(b_busy), 32'(tbl[r].busy));
            for (int i = 0; i < 8; i++) tick();
        end
        b_en = 1'b1;

        // Randomised traffic on both builds against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) a_d = ~a_d;
            if ($urandom_range(3) == 0) b_d = ~b_d;
            a_sel = 2'($urandom_range(3));
            b_sel = 2'($urandom_range(3));
            a_en  = ($urandom_range(7) != 0);
            b_en  = ($urandom_range(7) != 0);
            a_clr = ($urandom_range(39) == 0);
            b_clr = ($urandom_range(39) == 0);
            rst   = ($urandom_range(499) == 0);
            tick();
        end
        rst = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
